// File: rtl/ariane_pkg.sv
// Shared core types: RoCC command/response payloads plus the command-arbiter
// tag depth and state encoding.
package ariane_pkg;

    localparam int unsigned ROCC_TAG_DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } rocc_cmd_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } rocc_resp_t;

    typedef enum logic {
        ARB,
        LOCK
    } rocc_arb_state_e;

endpackage

// File: rtl/rocc_tag_fifo.sv
// Small FIFO of requester IDs; one entry per response-bearing command in flight.
// Push is ignored when full, pop is ignored when empty.
module rocc_tag_fifo #(
    parameter  int unsigned Width = 1,
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin share of one RoCC command/response port among NumReq requesters;
// a stalled grant is locked until accepted, responses are routed via a tag FIFO.
module rocc_cmd_arbiter
    import ariane_pkg::*;
#(
    parameter  int unsigned NumReq   = 2,
    parameter  int unsigned TagDepth = ROCC_TAG_DEPTH,
    localparam int unsigned IdW      = $clog2(NumReq),
    localparam int unsigned CntW     = $clog2(TagDepth) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  rocc_cmd_t [NumReq-1:0] req_cmd_i,
    input  logic [NumReq-1:0]      req_xd_i,
    output logic [NumReq-1:0]      rsp_valid_o,
    input  logic [NumReq-1:0]      rsp_ready_i,
    output rocc_resp_t             rsp_o,
    output rocc_cmd_t              rocc_cmd_o,
    output logic                   rocc_cmd_valid_o,
    input  logic                   rocc_cmd_ready_i,
    input  rocc_resp_t             rocc_resp_i,
    input  logic                   rocc_resp_valid_i,
    output logic                   rocc_resp_ready_o,
    output logic [CntW-1:0]        outstanding_o,
    output logic                   spurious_o
);

    // Returns {found, index} of the first eligible requester at or after ptr.
    function automatic logic [IdW:0] rr_pick(input logic [NumReq-1:0] elig,
                                              input logic [IdW-1:0]    ptr);
        logic [IdW:0] res;
        int unsigned  idx;
        res = '0;
        for (int unsigned k = NumReq; k > 0; k--) begin
            idx = (32'(ptr) + k - 1) % NumReq;
            if (elig[idx]) res = {1'b1, IdW'(idx)};
        end
        return res;
    endfunction

    rocc_arb_state_e   state_q, state_d;
    logic [IdW-1:0]    lock_id_q, lock_id_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              spurious_q, spurious_d;

    logic [NumReq-1:0] eligible;
    logic [IdW:0]      pick;
    logic [IdW-1:0]    sel;
    logic              sel_vld;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IdW-1:0]    head;

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            eligible[i] = req_valid_i[i] && (!req_xd_i[i] || !fifo_full);
        end
        pick = rr_pick(eligible, rr_ptr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            spurious_q <= spurious_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ARB: begin
                lock_id_d = sel;
                if (sel_vld && !rocc_cmd_ready_i) state_d = LOCK;
            end
            LOCK: begin
                if (rocc_cmd_ready_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
        if (accept) begin
            rr_ptr_d = (sel == IdW'(NumReq - 1)) ? '0 : sel + 1'b1;
        end
    end

    // A locked grant was eligible when captured, and no push can happen
    // while locked, so it needs no re-check against FIFO occupancy.
    always_comb begin
        if (state_q == LOCK) begin
            sel     = lock_id_q;
            sel_vld = 1'b1;
        end else begin
            sel     = pick[IdW-1:0];
            sel_vld = pick[IdW];
        end
        rocc_cmd_o       = req_cmd_i[sel];
        rocc_cmd_valid_o = sel_vld;
        req_ready_o      = '0;
        if (sel_vld) req_ready_o[sel] = rocc_cmd_ready_i;
        accept = sel_vld && rocc_cmd_ready_i;
        push   = accept && req_xd_i[sel];
    end

    assign rsp_o = rocc_resp_i;

    always_comb begin
        rsp_valid_o       = '0;
        rocc_resp_ready_o = 1'b1;
        pop               = 1'b0;
        spurious_d        = spurious_q;
        if (!fifo_empty) begin
            rsp_valid_o[head] = rocc_resp_valid_i;
            rocc_resp_ready_o = rsp_ready_i[head];
            pop               = rocc_resp_valid_i && rsp_ready_i[head];
        end else if (rocc_resp_valid_i) begin
            spurious_d = 1'b1;
        end
    end

    assign spurious_o = spurious_q;

    rocc_tag_fifo #(
        .Width (IdW),
        .Depth (TagDepth)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (sel),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: doc/rocc_cmd_arbiter.md
# rocc_cmd_arbiter

Shares a single RoCC accelerator command/response port between `NumReq` requesters, each typically a per-core `rocc` issue unit. Command arbitration is round-robin. Responses come back in order and are routed to their owner through a FIFO of requester IDs. Sits between the RoCC functional units and the accelerator, so it sees the accelerator's `rocc_cmd_t`/`rocc_resp_t` handshakes on one side and one replica per requester on the other.

## Interface
- `NumReq`, default 2: number of requesters, at least 2.
- `TagDepth`, default 4: maximum number of response-bearing commands in flight; power of two.
- `clk_i`, input, 1: clock. One clock; reset is synchronous and active-high.
- `rst_i`, input, 1: synchronous active-high reset.
- `req_valid_i`, input, NumReq: command valid, one bit per requester.
- `req_ready_o`, output, NumReq: command accepted, one bit per requester.
- `req_cmd_i`, input, NumReq x rocc_cmd_t: command payload per requester.
- `req_xd_i`, input, NumReq: 1 means the command expects a response.
- `rsp_valid_o`, output, NumReq: response valid, one-hot to the owning requester.
- `rsp_ready_i`, input, NumReq: requester can take the response.
- `rsp_o`, output, rocc_resp_t: response payload, broadcast to all requesters.
- `rocc_cmd_o`, output, rocc_cmd_t: command to the accelerator.
- `rocc_cmd_valid_o`, output, 1: command valid to the accelerator.
- `rocc_cmd_ready_i`, input, 1: accelerator accepts the command.
- `rocc_resp_i`, input, rocc_resp_t: response from the accelerator.
- `rocc_resp_valid_i`, input, 1: accelerator response valid.
- `rocc_resp_ready_o`, output, 1: arbiter accepts the response.
- `outstanding_o`, output, clog2(TagDepth)+1: current tag FIFO occupancy.
- `spurious_o`, output, 1: sticky flag; set when a response arrives with no entry in the tag FIFO.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` is high and either `req_xd_i[i]` is 0 or the FIFO is not full.
- **States.** Two states:
  - ARB: select the first eligible requester at or after `rr_ptr`, wrapping at NumReq.
  - LOCK: drive the selection held in `lock_id_q`.
- **Command path.**
  - `rocc_cmd_o` carries the selected requester's `req_cmd_i`.
  - `rocc_cmd_valid_o` is high when any requester is selected.
  - `req_ready_o[sel]` equals `rocc_cmd_ready_i`; all other `req_ready_o` bits are 0.
- **ARB to LOCK.** Taken when `rocc_cmd_valid_o` is high and `rocc_cmd_ready_i` is low. `lock_id_q` captures `sel`.
- **LOCK behaviour.** The held selection is driven even if a higher-priority requester becomes valid. Requesters must keep valid and payload stable, per AXI-style rules.
- **LOCK to ARB.** Taken when `rocc_cmd_ready_i` is high.
- **Round-robin pointer.** On every accepted command, `rr_ptr` becomes `sel + 1` modulo NumReq.
- **Push.** An accepted command with `req_xd_i[sel]` = 1 pushes `sel` into the tag FIFO. A command with xd = 0 does not push.
- **Response routing.**
  - `rsp_o` equals `rocc_resp_i`.
  - With the FIFO non-empty, `rsp_valid_o[head]` equals `rocc_resp_valid_i` and `rocc_resp_ready_o` equals `rsp_ready_i[head]`.
  - Pop when `rocc_resp_valid_i` and `rocc_resp_ready_o` are both high.
- **Spurious response.** With the FIFO empty, `rocc_resp_ready_o` is 1 (the response is dropped), all `rsp_valid_o` bits are 0, and `spurious_o` is set if `rocc_resp_valid_i` is high.
- **Occupancy.** `outstanding_o` equals pushes minus pops. Push and pop in the same cycle leaves it unchanged.

## Timing
- **Reset.** Reset applies on the first rising edge with `rst_i` high. Reset values:
  - state ARB, `rr_ptr` 0, FIFO empty, `outstanding_o` 0, `spurious_o` 0.
  - Outputs then settle to `rocc_cmd_valid_o` 0, `req_ready_o` all 0, `rsp_valid_o` all 0, and `rocc_resp_ready_o` 1 (FIFO empty).
- **Reset mid-transfer.** Reset in LOCK or with entries in flight discards everything. Responses to those entries then count as spurious.
- **Command latency.** Zero cycles combinational: request valid to `rocc_cmd_valid_o` in the same cycle.
- **Response latency.** Zero cycles combinational to `rsp_valid_o`.
- **Registered state.** Pointer, lock, and FIFO update on the clock edge.
- **FIFO full.** Pushes are blocked. A same-cycle pop does not enable a push; the push proceeds the next cycle.
- **FIFO empty.** A push and a response arriving in the same cycle: the response is treated as spurious and the pushed entry remains.
- **Combinational paths.** No path from `rsp_ready_i` to `req_ready_o`. The only combinational loop-free paths are ready to ready and valid to valid, each across one side only.

## Structure
- `rocc_cmd_t` and `rocc_resp_t` stay in `ariane_pkg`.
- Add to `ariane_pkg`:
  - `ROCC_TAG_DEPTH`.
  - `rocc_arb_state_e`, with values ARB and LOCK.
- Sub-module `rocc_tag_fifo`:
  - Parameterised width and depth; stores requester IDs.
  - Ports: push, pop, data in, data out, full, empty, count.
  - Synchronous active-high reset.
- Round-robin select is an inline function in the top module.

## Test plan
- **Single command with response.** NumReq=2; requester 0 sends an xd=1 command with `rocc_cmd_ready_i`=1. Expect `rocc_cmd_o` to equal requester 0's command in that cycle and `outstanding_o` to be 1. A later response sets `rsp_valid_o` to 01, and `outstanding_o` returns to 0.
- **Round-robin fairness.** Both requesters valid every cycle, ready always 1. Expect grants in the order 0,1,0,1 over 4 cycles and `rr_ptr` to alternate.
- **Lock.** Requester 1 is granted with ready 0 for 3 cycles while requester 0 is valid. Expect `rocc_cmd_o` to stay on requester 1's command. On the 4th cycle ready goes to 1; requester 1 is accepted and requester 0 is granted the next cycle.
- **Full FIFO.** TagDepth=4; issue 4 xd=1 commands with no responses. Expect `outstanding_o`=4 and a 5th xd=1 command to be blocked (`req_ready_o`=0). An xd=0 command from the other requester is still accepted.
- **Response backpressure.** FIFO head is requester 1 and `rsp_ready_i[1]`=0. Expect `rocc_resp_ready_o`=0 and the FIFO unchanged. When `rsp_ready_i[1]` goes to 1, expect a pop.
- **Spurious and reset.** A response arrives with the FIFO empty: expect `spurious_o`=1 and `rocc_resp_ready_o`=1. Assert `rst_i` while in LOCK with 2 entries in flight: expect state ARB, `outstanding_o`=0 and `spurious_o`=0 after the edge.
